// File: rtl/exit_status_uart_reporter_pkg.sv
// exit_status_uart_reporter_pkg: shared state encoding, message constants and ASCII helpers for the exit reporter
package exit_report_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] NEXT  = 3'd4;
  localparam int unsigned MSG_LEN = 15;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return {4'h0, n} + (n > 4'd9 ? 8'h37 : 8'h30);
  endfunction
  // Message is "EXIT:" + 8 hex digits (MSB nibble first) + CR LF
  function automatic logic [7:0] msg_char(input logic [3:0] idx, input logic [31:0] v);
    logic [4:0] sh;
    sh = {3'(4'd12 - idx), 2'b00};
    case (idx)
      4'd0:    return CH_E;
      4'd1:    return CH_X;
      4'd2:    return CH_I;
      4'd3:    return CH_T;
      4'd4:    return CH_COLON;
      4'd13:   return CH_CR;
      4'd14:   return CH_LF;
      default: return nibble_to_ascii(v[sh +: 4]);
    endcase
  endfunction
endpackage

// File: rtl/exit_status_uart_reporter_if.sv
// exit_status_uart_reporter_if: exit strobe/value inputs and UART/status outputs of the exit reporter
interface exit_status_uart_reporter_if;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] latched_value_o;
  modport master (output exit_valid_i, exit_value_i, input tx_o, busy_o, done_o, latched_value_o);
  modport slave (input exit_valid_i, exit_value_i, output tx_o, busy_o, done_o, latched_value_o);
endinterface

// File: rtl/exit_status_uart_reporter_uart_tx_byte.sv
// uart_tx_byte: 8N1 LSB-first byte serialiser; byte_ready is also high on the last stop-bit cycle so bytes can chain
module uart_tx_byte
  import exit_report_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clk_gen,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx_o
);
  localparam int BW = $clog2(BAUD_DIV);
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_end;
  always_comb begin
    bit_end = baud_q == BW'(BAUD_DIV - 1);
    byte_ready = state_q == IDLE || (state_q == STOP && bit_end);
    tx_o = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    if (byte_valid && byte_ready) begin
      state_d = START;
      shift_d = byte_data;
    end else if (bit_end && state_q == START) begin
      state_d = DATA;
      bit_d = '0;
    end else if (bit_end && state_q == DATA) begin
      shift_d = shift_q >> 1;
      bit_d = bit_q + 1'b1;
      state_d = bit_q == 3'd7 ? STOP : DATA;
    end else if (bit_end && state_q == STOP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/exit_status_uart_reporter.sv
// exit_status_uart_reporter: on an exit_valid rising edge, latch the exit value and send "EXIT:XXXXXXXX\r\n" over UART.
// Define EXIT_REPORT_REPEAT_EN to re-send the latched value every REPEAT_PERIOD cycles while exit_valid stays high.
module exit_status_uart_reporter
  import exit_report_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 15000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned REPEAT_PERIOD = 15000000
) (
  input logic                         clk_gen,
  input logic                         rst_n,
  exit_status_uart_reporter_if.slave  bus
);
  localparam int unsigned BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
  if (BAUD_DIV < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
    $error("exit_status_uart_reporter: BAUD_DIV and REPEAT_PERIOD must be >= 2");
  end
  logic [2:0]  state_q, state_d;
  logic [3:0]  char_idx_q, char_idx_d;
  logic [31:0] latched_q, latched_d;
  logic        exit_valid_q;
  logic        edge_det, start_msg, rpt_fire, last_char, done;
  logic        byte_valid, byte_ready, tx;
  logic [7:0]  byte_data;
  // START here spans the serialiser's whole START/DATA/STOP frame for the current char
  always_comb begin
    edge_det = bus.exit_valid_i & ~exit_valid_q;
    last_char = char_idx_q == 4'(MSG_LEN - 1);
    done = state_q == NEXT && last_char;
    start_msg = state_q == IDLE && (edge_det || rpt_fire);
    byte_valid = start_msg || (state_q == NEXT && !last_char);
    state_d = state_q;
    char_idx_d = char_idx_q;
    latched_d = latched_q;
    if (start_msg) begin
      state_d = START;
      char_idx_d = '0;
      latched_d = edge_det ? bus.exit_value_i : latched_q;
    end else if (state_q == START && byte_ready) begin
      state_d = NEXT;
    end else if (state_q == NEXT) begin
      state_d = last_char ? IDLE : START;
      char_idx_d = last_char ? char_idx_q : char_idx_q + 4'd1;
    end
    byte_data = msg_char(char_idx_d, latched_d);
  end
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      char_idx_q <= '0;
      latched_q <= '0;
      exit_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      char_idx_q <= char_idx_d;
      latched_q <= latched_d;
      exit_valid_q <= bus.exit_valid_i;
    end
  end
`ifdef EXIT_REPORT_REPEAT_EN
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  logic          rpt_on_q, rpt_on_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  assign rpt_fire = rpt_on_q && bus.exit_valid_i && state_q == IDLE && rpt_cnt_q == RW'(REPEAT_PERIOD - 1);
  // The done cycle counts as period cycle 0, so the re-send starts REPEAT_PERIOD cycles after done_o
  always_comb begin
    rpt_on_d = rpt_on_q;
    rpt_cnt_d = rpt_cnt_q;
    if (!bus.exit_valid_i || start_msg) begin
      rpt_on_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (done) begin
      rpt_on_d = 1'b1;
      rpt_cnt_d = RW'(1);
    end else if (rpt_on_q) begin
      rpt_cnt_d = rpt_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      rpt_on_q <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      rpt_on_q <= rpt_on_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif
  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk_gen    (clk_gen),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .tx_o       (tx)
  );
  assign bus.tx_o = tx;
  assign bus.busy_o = state_q == START || (state_q == NEXT && !last_char);
  assign bus.done_o = done;
  assign bus.latched_value_o = latched_q;
endmodule

// File: tb/tb_exit_status_uart_reporter.sv
// tb_exit_status_uart_reporter: directed bench with BAUD_DIV=16 (161 cycles per char incl. gap)
module tb_exit_status_uart_reporter;
  localparam int MSG_CYC = 15 * 161;
  logic clk_gen = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  exit_status_uart_reporter_if bus ();
  exit_status_uart_reporter #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .REPEAT_PERIOD(100)) dut (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .bus     (bus)
  );
  always #5 clk_gen = ~clk_gen;
  always @(posedge clk_gen) cyc <= cyc + 1;
  always @(negedge clk_gen) if (bus.done_o === 1'b1) done_cnt++;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic rx_msg(output logic [119:0] m, output int first, output int err);
    int t0, prev;
    logic [159:0] s;
    err = 0; m = '0; first = -1; prev = 0;
    for (int c = 0; c < 15; c++) begin
      int w;
      w = 0;
      while (bus.tx_o !== 1'b0 && w < 400) begin @(negedge clk_gen); w++; end
      if (w >= 400) begin err++; return; end
      t0 = cyc;
      if (c == 0) first = t0; else if (t0 - prev != 161) err++;
      prev = t0;
      for (int j = 0; j < 160; j++) begin s[j] = bus.tx_o; @(negedge clk_gen); end
      for (int j = 0; j < 160; j++) if (s[j] !== s[j / 16 * 16]) err++;
      if (s[0] !== 1'b0 || s[144] !== 1'b1) err++;
      for (int b = 0; b < 8; b++) m[8 * (14 - c) + b] = s[16 * (b + 1)];
    end
  endtask

  task automatic edge_at(input logic [31:0] v, output int ecyc);
    @(negedge clk_gen);
    bus.exit_value_i = v;
    bus.exit_valid_i = 1'b1;
    ecyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.exit_valid_i = 1'b0; bus.exit_value_i = '0;
    repeat (2) @(negedge clk_gen);
    n_checks++; if (bus.tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", bus.tx_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    n_checks++; if (bus.latched_value_o !== 32'h0) begin n_fail++; $display("FAIL reset_latched: got %h want 0", bus.latched_value_o); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk_gen);
    n_checks++; if (bus.tx_o !== 1'b1) begin n_fail++; $display("FAIL idle_tx: got %b want 1", bus.tx_o); end
  endtask

  task automatic test_basic();
    int e, f, err, dc, d0;
    logic [119:0] m;
    d0 = done_cnt;
    edge_at(32'h0000002A, e);
    rx_msg(m, f, err);
    dc = cyc;
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL basic_done_at_end: got %b want 1", bus.done_o); end
    bus.exit_valid_i = 1'b0;
    n_checks++; if (f != e + 1) begin n_fail++; $display("FAIL basic_start_latency: got %0d want %0d", f, e + 1); end
    n_checks++; if (err != 0) begin n_fail++; $display("FAIL basic_framing: got %0d errors want 0", err); end
    n_checks++; if (m !== {"EXIT:0000002A", 8'h0D, 8'h0A}) begin n_fail++; $display("FAIL basic_msg: got %h want %h", m, {"EXIT:0000002A", 8'h0D, 8'h0A}); end
    n_checks++; if (dc != f + MSG_CYC - 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, f + MSG_CYC - 1); end
    n_checks++; if (bus.latched_value_o !== 32'h2A) begin n_fail++; $display("FAIL basic_latched: got %h want 2a", bus.latched_value_o); end
    repeat (2) @(negedge clk_gen);
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_uppercase();
    int e, f, err;
    logic [119:0] m;
    edge_at(32'hDEADBEEF, e);
    rx_msg(m, f, err);
    bus.exit_valid_i = 1'b0;
    n_checks++; if (m !== {"EXIT:DEADBEEF", 8'h0D, 8'h0A}) begin n_fail++; $display("FAIL upper_msg: got %h want %h", m, {"EXIT:DEADBEEF", 8'h0D, 8'h0A}); end
    n_checks++; if (m[79:48] !== 32'h44454144) begin n_fail++; $display("FAIL upper_idx5_8: got %h want 44454144", m[79:48]); end
    n_checks++; if (err != 0) begin n_fail++; $display("FAIL upper_bit_width: got %0d errors want 0", err); end
    n_checks++; if (f != e + 1) begin n_fail++; $display("FAIL upper_start_latency: got %0d want %0d", f, e + 1); end
    repeat (2) @(negedge clk_gen);
  endtask

  task automatic test_busy_ignore();
    int e, f, err;
    logic [119:0] m;
    edge_at(32'h89ABCDEF, e);
    fork
      rx_msg(m, f, err);
      begin
        repeat (1 + 3 * 161 + 20) @(negedge clk_gen);
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_mid: got %b want 1", bus.busy_o); end
        bus.exit_valid_i = 1'b0;
        @(negedge clk_gen);
        bus.exit_value_i = 32'h1;
        bus.exit_valid_i = 1'b1;
        @(negedge clk_gen);
        n_checks++; if (bus.latched_value_o !== 32'h89ABCDEF) begin n_fail++; $display("FAIL ignore_latched_mid: got %h want 89abcdef", bus.latched_value_o); end
      end
    join
    bus.exit_valid_i = 1'b0;
    n_checks++; if (m !== {"EXIT:89ABCDEF", 8'h0D, 8'h0A}) begin n_fail++; $display("FAIL ignore_msg: got %h want %h", m, {"EXIT:89ABCDEF", 8'h0D, 8'h0A}); end
    n_checks++; if (err != 0) begin n_fail++; $display("FAIL ignore_framing: got %0d errors want 0", err); end
    n_checks++; if (bus.latched_value_o !== 32'h89ABCDEF) begin n_fail++; $display("FAIL ignore_latched_end: got %h want 89abcdef", bus.latched_value_o); end
    repeat (2) @(negedge clk_gen);
  endtask

  task automatic test_reset_mid();
    int e, ones;
    edge_at(32'h13572468, e);
    // char 7 is '5' (0x35): data bit 1 is 0
    repeat (1 + 7 * 161 + 40) @(negedge clk_gen);
    n_checks++; if (bus.tx_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit1: got %b want 0", bus.tx_o); end
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy_o); end
    rst_n = 1'b0;
    bus.exit_valid_i = 1'b0;
    #1;
    n_checks++; if (bus.tx_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_async: got %b want 1", bus.tx_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_async: got %b want 0", bus.busy_o); end
    @(negedge clk_gen);
    rst_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 500; i++) begin @(negedge clk_gen); if (bus.tx_o === 1'b1) ones++; end
    n_checks++; if (ones != 500) begin n_fail++; $display("FAIL rstmid_idle_500: got %0d high cycles want 500", ones); end
    n_checks++; if (bus.latched_value_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_latched: got %h want 0", bus.latched_value_o); end
  endtask

  task automatic test_held_high();
    int e, f, err, dc, d0;
    logic [119:0] m;
    d0 = done_cnt;
    edge_at(32'h0BADF00D, e);
    rx_msg(m, f, err);
    dc = cyc;
    n_checks++; if (m !== {"EXIT:0BADF00D", 8'h0D, 8'h0A} || err != 0) begin n_fail++; $display("FAIL held_msg: got %h err %0d want %h err 0", m, err, {"EXIT:0BADF00D", 8'h0D, 8'h0A}); end
`ifdef EXIT_REPORT_REPEAT_EN
    begin
      int w;
      w = 0;
      while (bus.tx_o !== 1'b0 && w < 300) begin @(negedge clk_gen); w++; end
      n_checks++; if (cyc - dc != 100) begin n_fail++; $display("FAIL repeat_delay: got %0d want 100", cyc - dc); end
      n_checks++; if (bus.latched_value_o !== 32'h0BADF00D) begin n_fail++; $display("FAIL repeat_latched: got %h want 0badf00d", bus.latched_value_o); end
      bus.exit_valid_i = 1'b0;
      w = 0;
      while (bus.busy_o !== 1'b0 && w < 3000) begin @(negedge clk_gen); w++; end
      n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL repeat_finish: got busy %b want 0", bus.busy_o); end
    end
`else
    begin
      int lows;
      lows = 0;
      for (int i = 0; i < 3 * MSG_CYC; i++) begin @(negedge clk_gen); if (bus.tx_o !== 1'b1) lows++; end
      n_checks++; if (lows != 0) begin n_fail++; $display("FAIL held_no_resend: got %0d low cycles want 0", lows); end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL held_done_count: got %0d want 1", done_cnt - d0); end
      bus.exit_valid_i = 1'b0;
    end
`endif
    repeat (2) @(negedge clk_gen);
  endtask

  task automatic test_done_edge();
    int e, f, err, ec;
    logic [119:0] m;
    edge_at(32'h00C0FFEE, e);
    @(negedge clk_gen);
    bus.exit_valid_i = 1'b0;
    rx_msg(m, f, err);
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL doneedge_done: got %b want 1", bus.done_o); end
    bus.exit_value_i = 32'h77777777;
    bus.exit_valid_i = 1'b1;
    @(negedge clk_gen);
    n_checks++; if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL doneedge_ignored: got tx %b busy %b want tx 1 busy 0", bus.tx_o, bus.busy_o); end
    n_checks++; if (bus.latched_value_o !== 32'h00C0FFEE) begin n_fail++; $display("FAIL doneedge_latched: got %h want 00c0ffee", bus.latched_value_o); end
    bus.exit_valid_i = 1'b0;
    @(negedge clk_gen);
    edge_at(32'h00000005, e);
    @(negedge clk_gen);
    bus.exit_valid_i = 1'b0;
    rx_msg(m, f, err);
    n_checks++; if (m !== {"EXIT:00000005", 8'h0D, 8'h0A} || err != 0) begin n_fail++; $display("FAIL doneedge_msg1: got %h err %0d", m, err); end
    @(negedge clk_gen);
    bus.exit_value_i = 32'hFEEDFACE;
    bus.exit_valid_i = 1'b1;
    ec = cyc;
    @(negedge clk_gen);
    n_checks++; if (bus.tx_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL after_done_edge: got tx %b busy %b want tx 0 busy 1", bus.tx_o, bus.busy_o); end
    rx_msg(m, f, err);
    bus.exit_valid_i = 1'b0;
    n_checks++; if (f != ec + 1) begin n_fail++; $display("FAIL after_done_latency: got %0d want %0d", f, ec + 1); end
    n_checks++; if (m !== {"EXIT:FEEDFACE", 8'h0D, 8'h0A} || err != 0) begin n_fail++; $display("FAIL after_done_msg: got %h err %0d want %h", m, err, {"EXIT:FEEDFACE", 8'h0D, 8'h0A}); end
    repeat (2) @(negedge clk_gen);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_uppercase();
    test_busy_ignore();
    test_reset_mid();
    test_held_high();
    test_done_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/exit_status_uart_reporter.md
Name: exit_status_uart_reporter

Overview:
Downstream consumer of the FPGA wrapper's exit signals (32-bit exit value plus exit-valid strobe from the x_heep_system instance).
- On the rising edge of exit-valid, latches the full 32-bit exit value.
- Transmits it once as ASCII "EXIT:XXXXXXXX\r\n" over a dedicated 8N1 debug UART pin.
- Board-level exit status becomes visible without JTAG, not just bit 0 on an LED.
- Sits in the FPGA wrapper, clocked by the generated clock.

Parameters:
CLK_FREQ_HZ, 15000000, frequency of clk_gen in Hz
BAUD_RATE, 115200, UART bit rate
BAUD_DIV, CLK_FREQ_HZ/BAUD_RATE (localparam, truncating), clk_gen cycles per UART bit; must be >= 2
REPEAT_PERIOD, 15000000, cycles between re-sends (optional feature only)

Ports:
clk_gen  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
exit_valid_i  in  1  exit strobe/level from the MCU, same clock domain
exit_value_i  in  32  exit value, sampled on the exit_valid_i rising edge
tx_o  out  1  UART TX, idle high
busy_o  out  1  high while a message is in flight
done_o  out  1  one-cycle pulse after the last stop bit of LF
latched_value_o  out  32  last captured exit value

Behaviour:
- Reset values (async): tx_o=1, busy_o=0, done_o=0, latched_value_o=0, FSM=IDLE, all counters 0, exit_valid_q=0.
- Edge detect: exit_valid_q registers exit_valid_i; edge = exit_valid_i & ~exit_valid_q. No synchroniser, because the signal is in the same clock domain.
- Capture:
  - An edge in IDLE at cycle N latches exit_value_i into latched_value_o, sets busy_o=1 and char_idx=0.
  - FSM enters START; tx_o=0 from cycle N+1.
- Message: 15 chars, idx 0..14 = 'E','X','I','T',':', hex nibbles [31:28] down to [3:0], 0x0D, 0x0A.
  - Nibble n maps to 0x30+n for n<=9 and 0x37+n for n>=10 (uppercase).
  - Chars are generated combinationally from char_idx and latched_value_o; no ROM.
- Frame: 8N1, LSB first; every bit holds exactly BAUD_DIV cycles, counted by baud_cnt from 0 to BAUD_DIV-1.
- FSM states and transitions:
  - IDLE: tx_o=1. On edge → START.
  - START: tx_o=0 for BAUD_DIV cycles. Then load shift register with the current char, set bit_idx=0 → DATA.
  - DATA: tx_o=shift[0]. At bit end, shift right and increment bit_idx. After bit 7 → STOP.
  - STOP: tx_o=1 for BAUD_DIV cycles, then go to NEXT.
  - NEXT (1 cycle, tx_o=1):
    - If char_idx==14: done_o=1, busy_o=0 → IDLE.
    - Else: increment char_idx → START.
- Inter-char gap: exactly 1 extra idle cycle per char, from NEXT. Total message length = 15*(10*BAUD_DIV+1) cycles from the first START cycle to the done_o cycle inclusive.
- Edges while busy_o=1 are ignored; the value is not re-latched.
- exit_valid_i falling mid-message has no effect; the message completes.
- exit_valid_i held high after done_o produces no re-send (edge-triggered only).
- Edge coinciding with the done_o cycle (FSM in NEXT) is ignored. Edge on the cycle after done_o (FSM back in IDLE) is accepted.
- Reset asserted mid-frame forces tx_o=1 immediately and aborts the message. No partial resume after reset release.

Optional Feature:
EXIT_REPORT_REPEAT_EN
- Defined: after done_o, a REPEAT_PERIOD-cycle counter runs while exit_valid_i=1. On expiry, the FSM re-sends the same latched value without re-latching. A falling exit_valid_i clears and stops the counter. A new rising edge still re-latches.
- Undefined: counter logic absent; exactly one message per rising edge.

Decomposition:
- Shared package exit_report_pkg:
  - state enum (IDLE, START, DATA, STOP, NEXT)
  - MSG_LEN=15
  - prefix byte constants
  - function nibble_to_ascii(logic [3:0]) returning logic [7:0]
- Sub-module uart_tx_byte: START/DATA/STOP bit serialiser with baud counter. Handshake: byte_valid/byte_ready plus tx_o.
- Top-level FSM: char_idx sequencing, capture, and repeat logic.

Test Plan:
- CLK_FREQ_HZ=16, BAUD_RATE=1 (BAUD_DIV=16); edge with exit_value_i=0x0000002A → decoded "EXIT:0000002A\r\n", done_o pulses once at cycle 15*161 after first START, latched_value_o=0x2A.
- exit_value_i=0xDEADBEEF → "EXIT:DEADBEEF\r\n"; bytes 0x44,0x45,0x41,0x44 at idx 5..8 (uppercase check); every bit 16 cycles wide.
- Second edge at char_idx=3 with value 0x1 → ignored; message still reports first value; latched_value_o unchanged.
- rst_n low during DATA of char 7 → tx_o=1 same cycle, busy_o=0. After release with no new edge, tx_o stays 1 for 500 cycles.
- exit_valid_i held high for 3 message lengths → exactly one message. With EXIT_REPORT_REPEAT_EN and REPEAT_PERIOD=100 → re-send starts 100 cycles after done_o.
- Edge in the done_o cycle → ignored; edge one cycle later → new message, tx_o=0 the following cycle.
